mac_pe: RTL and testbench
=========================

# mac_pe

Parametrised weight-stationary processing element for the TPU systolic array. It is the next generation of the 8-bit MAC cell. Each cycle it multiplies the west activation by a locally held weight, adds the north partial sum, and forwards results south and activations east. New features over the 8-bit cell: valid tagging, a double-buffered (shadow/active) weight with a shift-in load chain, signed saturation and sticky error flags.

## Interface
- `DATA_W`, 8: activation and weight width (signed two's complement).
- `ACC_W`, 24: partial-sum width. Must be ≥ 2*DATA_W; elaboration error otherwise.
- `SATURATE`, 1: 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `act_in`  in  DATA_W  activation from west.
- `act_valid_in`  in  1  `act_in` qualifier.
- `act_out`  out  DATA_W  activation to east.
- `act_valid_out`  out  1  `act_out` qualifier.
- `psum_in`  in  ACC_W  partial sum from north.
- `psum_valid_in`  in  1  `psum_in` qualifier.
- `psum_out`  out  ACC_W  partial sum to south.
- `psum_valid_out`  out  1  `psum_out` qualifier.
- `wt_in`  in  DATA_W  weight chain input from north.
- `wt_shift_in`  in  1  shift strobe for the weight chain.
- `wt_out`  out  DATA_W  weight chain output to south.
- `wt_shift_out`  out  1  registered `wt_shift_in`.
- `wt_swap_in`  in  1  commit shadow weight to active.
- `wt_swap_out`  out  1  registered `wt_swap_in`.
- `flag_clr`  in  1  synchronous clear of sticky flags.
- `ovf_flag`  out  1  sticky; set on saturation/wrap.
- `err_flag`  out  1  sticky; set on valid misalignment or swap with empty shadow.

## Operation
- State: `shadow_w`, `shadow_full`, `active_w`, `active_ok`.
- Weight state machine:
  - EMPTY (shadow_full=0) → FULL on `wt_shift_in`.
  - FULL → EMPTY on `wt_swap_in` without a simultaneous shift.
  - FULL stays FULL on shift, or on swap plus shift.
- Shift: `shadow_w <= wt_in`; `wt_out <= shadow_w` (old value); `wt_shift_out <= wt_shift_in`. In a column of N cells, N shifts place the first-pushed weight in the bottom cell.
- Swap with shadow FULL: `active_w <= shadow_w` (pre-shift value); `active_ok <= 1`.
- Swap with shadow EMPTY: active weight unchanged, set `err_flag`.
- Swap and shift in the same cycle: old shadow goes to active; `wt_in` goes to shadow; shadow stays FULL.
- Compute, when `act_valid_in & psum_valid_in`:
  - Product = signed `act_in` * (`active_ok` ? `active_w` : 0), 2*DATA_W bits.
  - Sign-extend the product to ACC_W+1 bits and add the sign-extended `psum_in`.
  - If the sum is out of ACC_W signed range: clamp to max/min when SATURATE=1, else truncate. Set `ovf_flag` in both cases.
  - `psum_out` takes the result; `psum_valid_out <= 1`.
- When exactly one of `act_valid_in`/`psum_valid_in` is high: `psum_valid_out <= 0`, set `err_flag`.
- When neither is valid: `psum_valid_out <= 0`, `psum_out` holds.
- Activation forward: `act_out <= act_in` and `act_valid_out <= act_valid_in` every cycle, independent of weight state.
- Flags: `flag_clr` clears both sticky flags. A same-cycle set wins over clear.

## Timing
- All outputs registered. Latency is 1 cycle for act→east, psum→south, the weight chain, and swap propagation.
- Swap takes effect for compute in the cycle after `wt_swap_in`. The compute in the swap cycle itself uses the old active weight.
- Reset (asserted at any time, including mid-load or mid-compute): all outputs 0, all valids 0, both flags 0, `shadow_w`/`active_w` 0, `shadow_full`/`active_ok` 0. The first post-reset valid compute with no swap yields `psum_out = psum_in`.
- No backpressure; valid inputs are always consumed.

## Structure
- Shared package `tpu_pkg`: default `DATA_W`/`ACC_W`; functions `sat_max(ACC_W)`/`sat_min(ACC_W)`; the weight-state encoding (EMPTY=0, FULL=1).
- One combinational sub-module `mac_sat_add`, containing the multiply, extend, add and saturate logic. It outputs the result and an overflow bit. `mac_pe` holds all registers and the weight FSM.

## Test plan
- Shift `wt_in`=3, then swap, then `act_in`=5, `psum_in`=7, both valid → `psum_out`=22 with `psum_valid_out`=1 one cycle later; `act_out`=5.
- Signed case: active weight -128, `act_in`=-128, `psum_in`=2^23-1, SATURATE=1 → `psum_out`=8388607, `ovf_flag`=1. With SATURATE=0 the output wraps to -8372225.
- Swap and shift in the same cycle: shadow 4, `wt_in`=9 → active becomes 4, shadow becomes 9, `wt_out`=4 next cycle, shadow stays FULL.
- Swap with shadow EMPTY → `err_flag`=1 and the active weight is unchanged. `flag_clr` then clears the flag, except when a new error occurs in the same cycle.
- `act_valid_in`=1 with `psum_valid_in`=0 → `psum_valid_out`=0, `err_flag`=1. `act_out` still forwards with valid=1.
- Reset asserted mid-stream with valid data in flight → all outputs 0 immediately (asynchronous). After release, a compute with weights loaded before reset gives `psum_out = psum_in`.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU systolic array: default widths, saturation
// bounds and the shadow-weight state encoding.
package tpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;

    // Widest accumulator the saturation helpers can describe.
    localparam int ACC_W_MAX  = 63;

    // Shadow weight register occupancy.
    typedef enum logic {
        WT_EMPTY = 1'b0,
        WT_FULL  = 1'b1
    } wt_state_e;

    // Largest signed value representable in acc_w bits, right-aligned in 64 bits.
    function automatic logic signed [63:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in acc_w bits, right-aligned in 64 bits.
    function automatic logic signed [63:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational datapath of the processing element: signed multiply of the
// activation by the active weight, sign extension, accumulate with the north
// partial sum, and either clamp or wrap on signed overflow.
module mac_sat_add
    import tpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic [DATA_W-1:0] i_act,
    input  logic [DATA_W-1:0] i_wt,
    input  logic              i_wt_ok,
    input  logic [ACC_W-1:0]  i_psum,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [63:0] L_MAX = sat_max(ACC_W);
    localparam logic signed [63:0] L_MIN = sat_min(ACC_W);

    logic [DATA_W-1:0] w_wt_eff;
    logic [PROD_W-1:0] w_act_x;
    logic [PROD_W-1:0] w_wt_x;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_prod_ext;
    logic [SUM_W-1:0]  w_psum_ext;
    logic [SUM_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_max;
    logic [ACC_W-1:0]  w_min;

    // An unloaded active weight behaves as zero so the cell passes psum through.
    assign w_wt_eff = i_wt_ok ? i_wt : {DATA_W{1'b0}};

    // Operands are pre-extended to the product width; the truncated unsigned
    // product then equals the exact signed product, which always fits.
    assign w_act_x = {{DATA_W{i_act[DATA_W-1]}}, i_act};
    assign w_wt_x  = {{DATA_W{w_wt_eff[DATA_W-1]}}, w_wt_eff};
    assign w_prod  = w_act_x * w_wt_x;

    // One guard bit above ACC_W exposes signed overflow of the accumulate.
    assign w_prod_ext = {{(SUM_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_psum_ext = {i_psum[ACC_W-1], i_psum};
    assign w_sum      = w_prod_ext + w_psum_ext;

    assign w_max = L_MAX[ACC_W-1:0];
    assign w_min = L_MIN[ACC_W-1:0];

    // Overflow detect and clamp/wrap selection for the accumulated result.
    always_comb begin
        o_ovf    = 1'b0;
        o_result = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            o_ovf = 1'b1;
            if (SATURATE) begin
                o_result = w_sum[ACC_W] ? w_min : w_max;
            end else begin
                o_result = w_sum[ACC_W-1:0];
            end
        end else begin
            o_ovf    = 1'b0;
            o_result = w_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/mac_pe.sv
// Weight-stationary MAC processing element. Holds a double-buffered weight
// (shadow loaded through a shift chain, active used for compute), forwards
// activations east and partial sums south with one cycle of latency, and
// keeps sticky overflow/error flags.
module mac_pe
    import tpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_valid_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_valid_out,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_valid_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    input  logic [DATA_W-1:0] wt_in,
    input  logic              wt_shift_in,
    output logic [DATA_W-1:0] wt_out,
    output logic              wt_shift_out,
    input  logic              wt_swap_in,
    output logic              wt_swap_out,
    input  logic              flag_clr,
    output logic              ovf_flag,
    output logic              err_flag
);

    // Reject parameter sets where the accumulator cannot hold a full product.
    if ((ACC_W < 2 * DATA_W) || (ACC_W > ACC_W_MAX)) begin : g_bad_width
        $error("mac_pe: ACC_W must be >= 2*DATA_W and <= ACC_W_MAX");
    end

    // Weight storage and FSM
    wt_state_e         r_wt_state;
    logic [DATA_W-1:0] r_shadow_w;
    logic [DATA_W-1:0] r_active_w;
    logic              r_active_ok;
    logic [DATA_W-1:0] r_wt_out;
    logic              r_wt_shift_out;
    logic              r_wt_swap_out;

    // Datapath and flag registers
    logic [DATA_W-1:0] r_act_out;
    logic              r_act_valid_out;
    logic [ACC_W-1:0]  r_psum_out;
    logic              r_psum_valid_out;
    logic              r_ovf_flag;
    logic              r_err_flag;

    logic [ACC_W-1:0]  w_result;
    logic              w_ovf;
    logic              w_compute;
    logic              w_misalign;
    logic              w_swap_err;
    logic              w_err_set;
    logic              w_ovf_set;

    mac_sat_add #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_mac_sat_add (
        .i_act    (act_in),
        .i_wt     (r_active_w),
        .i_wt_ok  (r_active_ok),
        .i_psum   (psum_in),
        .o_result (w_result),
        .o_ovf    (w_ovf)
    );

    assign w_compute  = act_valid_in & psum_valid_in;
    assign w_misalign = act_valid_in ^ psum_valid_in;
    assign w_swap_err = wt_swap_in & (r_wt_state == WT_EMPTY);
    assign w_err_set  = w_misalign | w_swap_err;
    assign w_ovf_set  = w_compute & w_ovf;

    // Weight FSM: shadow fill/drain, swap into active, and the shift chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wt_state     <= WT_EMPTY;
            r_shadow_w     <= {DATA_W{1'b0}};
            r_active_w     <= {DATA_W{1'b0}};
            r_active_ok    <= 1'b0;
            r_wt_out       <= {DATA_W{1'b0}};
            r_wt_shift_out <= 1'b0;
            r_wt_swap_out  <= 1'b0;
        end else begin
            r_wt_shift_out <= wt_shift_in;
            r_wt_swap_out  <= wt_swap_in;
            if (wt_shift_in) begin
                r_shadow_w <= wt_in;
                r_wt_out   <= r_shadow_w;
            end
            case (r_wt_state)
                WT_EMPTY: begin
                    // A swap here is an error and leaves the active weight alone.
                    if (wt_shift_in) begin
                        r_wt_state <= WT_FULL;
                    end
                end
                WT_FULL: begin
                    if (wt_swap_in) begin
                        // Active takes the pre-shift shadow value.
                        r_active_w  <= r_shadow_w;
                        r_active_ok <= 1'b1;
                        r_wt_state  <= wt_shift_in ? WT_FULL : WT_EMPTY;
                    end
                end
                default: begin
                    r_wt_state <= WT_EMPTY;
                end
            endcase
        end
    end

    // Activation forwarding east, independent of weight state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_act_out       <= {DATA_W{1'b0}};
            r_act_valid_out <= 1'b0;
        end else begin
            r_act_out       <= act_in;
            r_act_valid_out <= act_valid_in;
        end
    end

    // Partial sum south: update on a valid pair, otherwise hold the data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_psum_out       <= {ACC_W{1'b0}};
            r_psum_valid_out <= 1'b0;
        end else if (w_compute) begin
            r_psum_out       <= w_result;
            r_psum_valid_out <= 1'b1;
        end else begin
            r_psum_valid_out <= 1'b0;
        end
    end

    // Sticky flags; a new event in the same cycle overrides the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovf_flag <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf_flag <= 1'b1;
            end else if (flag_clr) begin
                r_ovf_flag <= 1'b0;
            end
            if (w_err_set) begin
                r_err_flag <= 1'b1;
            end else if (flag_clr) begin
                r_err_flag <= 1'b0;
            end
        end
    end

    assign act_out        = r_act_out;
    assign act_valid_out  = r_act_valid_out;
    assign psum_out       = r_psum_out;
    assign psum_valid_out = r_psum_valid_out;
    assign wt_out         = r_wt_out;
    assign wt_shift_out   = r_wt_shift_out;
    assign wt_swap_out    = r_wt_swap_out;
    assign ovf_flag       = r_ovf_flag;
    assign err_flag       = r_err_flag;

endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: a saturating and a wrapping instance share stimulus.
module tb_mac_pe;

    logic        clock;
    logic        reset;
    logic [7:0]  act_in;
    logic        act_valid_in;
    logic [23:0] psum_in;
    logic        psum_valid_in;
    logic [7:0]  wt_in;
    logic        wt_shift_in;
    logic        wt_swap_in;
    logic        flag_clr;

    logic [7:0]  s_act_out,  w_act_out;
    logic        s_act_v,    w_act_v;
    logic [23:0] s_psum_out, w_psum_out;
    logic        s_psum_v,   w_psum_v;
    logic [7:0]  s_wt_out,   w_wt_out;
    logic        s_wt_shift, w_wt_shift;
    logic        s_wt_swap,  w_wt_swap;
    logic        s_ovf,      w_ovf;
    logic        s_err,      w_err;

    int checks = 0;
    int errors = 0;

    mac_pe #(.DATA_W(8), .ACC_W(24), .SATURATE(1'b1)) u_dut_sat (
        .clock(clock), .reset(reset),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(s_act_out), .act_valid_out(s_act_v),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .psum_out(s_psum_out), .psum_valid_out(s_psum_v),
        .wt_in(wt_in), .wt_shift_in(wt_shift_in),
        .wt_out(s_wt_out), .wt_shift_out(s_wt_shift),
        .wt_swap_in(wt_swap_in), .wt_swap_out(s_wt_swap),
        .flag_clr(flag_clr), .ovf_flag(s_ovf), .err_flag(s_err)
    );

    mac_pe #(.DATA_W(8), .ACC_W(24), .SATURATE(1'b0)) u_dut_wrap (
        .clock(clock), .reset(reset),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .act_out(w_act_out), .act_valid_out(w_act_v),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .psum_out(w_psum_out), .psum_valid_out(w_psum_v),
        .wt_in(wt_in), .wt_shift_in(wt_shift_in),
        .wt_out(w_wt_out), .wt_shift_out(w_wt_shift),
        .wt_swap_in(wt_swap_in), .wt_swap_out(w_wt_swap),
        .flag_clr(flag_clr), .ovf_flag(w_ovf), .err_flag(w_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        act_in = 8'd0; act_valid_in = 1'b0;
        psum_in = 24'd0; psum_valid_in = 1'b0;
        wt_in = 8'd0; wt_shift_in = 1'b0; wt_swap_in = 1'b0;
        flag_clr = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #23;
        // Reset state
        check("rst_psum",    {8'd0, s_psum_out}, 32'd0);
        check("rst_psum_v",  {31'd0, s_psum_v},  32'd0);
        check("rst_act_v",   {31'd0, s_act_v},   32'd0);
        check("rst_wt_out",  {24'd0, s_wt_out},  32'd0);
        check("rst_flags",   {30'd0, s_ovf, s_err}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic: shift 3, swap, 5*3+7 = 22
        wt_in = 8'd3; wt_shift_in = 1'b1;
        tick();
        check("shift_out",   {31'd0, s_wt_shift}, 32'd1);
        check("wt_out_old",  {24'd0, s_wt_out},   32'd0);
        idle(); wt_swap_in = 1'b1;
        tick();
        check("swap_out",    {31'd0, s_wt_swap}, 32'd1);
        check("swap_ok_err", {31'd0, s_err},     32'd0);
        idle(); act_in = 8'd5; act_valid_in = 1'b1; psum_in = 24'd7; psum_valid_in = 1'b1;
        tick();
        check("basic_psum",   {8'd0, s_psum_out}, 32'd22);
        check("basic_psum_v", {31'd0, s_psum_v},  32'd1);
        check("basic_act",    {24'd0, s_act_out}, 32'd5);
        check("basic_act_v",  {31'd0, s_act_v},   32'd1);
        check("basic_ovf",    {31'd0, s_ovf},     32'd0);
        idle();
        tick();
        check("idle_psum_v",  {31'd0, s_psum_v},  32'd0);
        check("idle_hold",    {8'd0, s_psum_out}, 32'd22);

        // Signed overflow: -128 * -128 + 8388607
        wt_in = 8'h80; wt_shift_in = 1'b1;
        tick();
        idle(); wt_swap_in = 1'b1;
        tick();
        idle(); act_in = 8'h80; act_valid_in = 1'b1; psum_in = 24'h7FFFFF; psum_valid_in = 1'b1;
        tick();
        check("sat_psum",  {8'd0, s_psum_out}, 32'h007FFFFF);
        check("sat_ovf",   {31'd0, s_ovf},     32'd1);
        check("wrap_psum", {8'd0, w_psum_out}, 32'h00803FFF);
        check("wrap_ovf",  {31'd0, w_ovf},     32'd1);
        idle(); flag_clr = 1'b1;
        tick();
        check("clr_ovf_s", {31'd0, s_ovf}, 32'd0);
        check("clr_ovf_w", {31'd0, w_ovf}, 32'd0);

        // Swap and shift together: shadow 4, wt_in 9
        idle(); wt_in = 8'd4; wt_shift_in = 1'b1;
        tick();
        check("wt_out_prev", {24'd0, s_wt_out}, 32'h80);
        idle(); wt_in = 8'd9; wt_shift_in = 1'b1; wt_swap_in = 1'b1;
        tick();
        check("ss_wt_out", {24'd0, s_wt_out}, 32'd4);
        idle(); act_in = 8'd1; act_valid_in = 1'b1; psum_in = 24'd0; psum_valid_in = 1'b1;
        tick();
        check("ss_active4", {8'd0, s_psum_out}, 32'd4);
        // Swap (shadow still full with 9) while computing: old weight used
        wt_swap_in = 1'b1;
        tick();
        check("swap_cycle_old", {8'd0, s_psum_out}, 32'd4);
        check("ss_full_no_err", {31'd0, s_err},     32'd0);
        idle(); act_in = 8'd2; act_valid_in = 1'b1; psum_in = 24'd1; psum_valid_in = 1'b1;
        tick();
        check("active9", {8'd0, s_psum_out}, 32'd19);

        // Swap with empty shadow
        idle(); wt_swap_in = 1'b1;
        tick();
        check("empty_swap_err", {31'd0, s_err},    32'd1);
        check("empty_swap_pv",  {31'd0, s_psum_v}, 32'd0);
        idle(); act_in = 8'd1; act_valid_in = 1'b1; psum_in = 24'd0; psum_valid_in = 1'b1;
        tick();
        check("active_kept", {8'd0, s_psum_out}, 32'd9);
        idle(); flag_clr = 1'b1;
        tick();
        check("clr_err", {31'd0, s_err}, 32'd0);
        idle(); flag_clr = 1'b1; wt_swap_in = 1'b1;
        tick();
        check("set_beats_clr", {31'd0, s_err}, 32'd1);
        idle(); flag_clr = 1'b1;
        tick();
        check("clr_err2", {31'd0, s_err}, 32'd0);

        // Valid misalignment
        idle(); act_in = 8'd6; act_valid_in = 1'b1;
        tick();
        check("mis_psum_v", {31'd0, s_psum_v},  32'd0);
        check("mis_err",    {31'd0, s_err},     32'd1);
        check("mis_act",    {24'd0, s_act_out}, 32'd6);
        check("mis_act_v",  {31'd0, s_act_v},   32'd1);

        // Reset mid-stream
        idle(); wt_in = 8'd7; wt_shift_in = 1'b1;
        tick();
        idle(); wt_swap_in = 1'b1;
        tick();
        idle(); act_in = 8'd3; act_valid_in = 1'b1; psum_in = 24'd10; psum_valid_in = 1'b1;
        tick();
        check("pre_rst_psum", {8'd0, s_psum_out}, 32'd31);
        #2;
        reset = 1'b0;
        #1;
        check("async_psum",   {8'd0, s_psum_out}, 32'd0);
        check("async_valids", {29'd0, s_psum_v, s_act_v, s_wt_shift}, 32'd0);
        check("async_act",    {24'd0, s_act_out}, 32'd0);
        check("async_flags",  {30'd0, s_ovf, s_err}, 32'd0);
        tick();
        #3;
        reset = 1'b1;
        tick();
        check("post_rst_psum",   {8'd0, s_psum_out}, 32'd10);
        check("post_rst_psum_v", {31'd0, s_psum_v},  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
